// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x480@60 VGA raster timing: sync pulses, 1-based pixel coordinates, frame tick
// Outputs are registered from the next-state counters so every output lines up with the counter edge.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int COORD_W  = 12
) (
  input  logic               CLOCK_25,
  input  logic               RESET,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               active,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] C_ONE      = COORD_W'(1);
  localparam logic [COORD_W-1:0] C_H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] C_V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] C_H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] C_V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] C_HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] C_HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] C_VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] C_VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL >= (1 << COORD_W)) begin : g_h_total_too_wide
    $error("vga_sync_gen: H_TOTAL does not fit in COORD_W bits");
  end
  if (V_TOTAL >= (1 << COORD_W)) begin : g_v_total_too_wide
    $error("vga_sync_gen: V_TOTAL does not fit in COORD_W bits");
  end

  logic [COORD_W-1:0] r_h_cnt;
  logic [COORD_W-1:0] r_v_cnt;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               r_active;
  logic               r_hsync;
  logic               r_vsync;
  logic               r_frame_tick;

  logic [COORD_W-1:0] w_h_nxt;
  logic [COORD_W-1:0] w_v_nxt;
  logic               w_active;
  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;
  logic               w_hsync;
  logic               w_vsync;
  logic               w_frame_tick;

  always_comb begin
    w_h_nxt = r_h_cnt + C_ONE;
    w_v_nxt = r_v_cnt;
    if (r_h_cnt == C_H_LAST) begin
      w_h_nxt = '0;
      w_v_nxt = (r_v_cnt == C_V_LAST) ? '0 : r_v_cnt + C_ONE;
    end

    // Decode from the next counter values so the registered outputs describe the same position as the counters
    w_active     = (w_h_nxt < C_H_ACT) && (w_v_nxt < C_V_ACT);
    w_x          = w_active ? w_h_nxt + C_ONE : '0;
    w_y          = w_active ? w_v_nxt + C_ONE : '0;
    w_hsync      = !((w_h_nxt >= C_HS_START) && (w_h_nxt < C_HS_END));
    w_vsync      = !((w_v_nxt >= C_VS_START) && (w_v_nxt < C_VS_END));
    w_frame_tick = (w_h_nxt == '0) && (w_v_nxt == C_V_ACT);
  end

  always_ff @(posedge CLOCK_25) begin
    if (RESET) begin
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_x          <= C_ONE;
      r_y          <= C_ONE;
      r_active     <= 1'b1;
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_h_cnt      <= w_h_nxt;
      r_v_cnt      <= w_v_nxt;
      r_x          <= w_x;
      r_y          <= w_y;
      r_active     <= w_active;
      r_hsync      <= w_hsync;
      r_vsync      <= w_vsync;
      r_frame_tick <= w_frame_tick;
    end
  end

  assign x          = r_x;
  assign y          = r_y;
  assign active     = r_active;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign frame_tick = r_frame_tick;

endmodule
